// File: rtl/duty_ramp.sv
// Ramps a registered PWM duty value toward a commanded target, one STEP every TICK_DIV clocks.
// Optional feature: define DUTY_RAMP_ESTOP_EN to add a synchronous emergency-stop input (estop).
module duty_ramp #(
  parameter int TICK_DIV = 2500,
  parameter int STEP     = 1,
  parameter int MAX_DUTY = 100
) (
  input  logic       clk,
  input  logic       rst,
`ifdef DUTY_RAMP_ESTOP_EN
  input  logic       estop,
`endif
  input  logic       en,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       clamped
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [15:0]       TICK_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]        MAX_U    = 8'(MAX_DUTY);
  localparam logic signed [8:0] MAX_S    = 9'(MAX_DUTY);
  localparam logic signed [8:0] STEP_S   = 9'(STEP);

  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  duty_q, duty_d;
  logic        clamped_q, clamped_d;

  logic              estop_w;
  logic              accept;
  logic signed [8:0] diff;
  logic signed [8:0] abs_diff;
  logic              last_step;

`ifdef DUTY_RAMP_ESTOP_EN
  assign estop_w = estop;
`else
  assign estop_w = 1'b0;
`endif

  // Saturate a requested duty to the clamp ceiling.
  function automatic logic [7:0] sat_target(input logic [7:0] d);
    return (d > MAX_U) ? MAX_U : d;
  endfunction

  // One STEP toward the target, saturated to 0..MAX_DUTY in 9-bit signed arithmetic.
  function automatic logic [7:0] step_toward(input logic signed [8:0] cur,
                                             input logic signed [8:0] dif);
    logic signed [8:0] nxt;
    nxt = (dif > 0) ? (cur + STEP_S) : (cur - STEP_S);
    if (nxt < 0)
      return 8'd0;
    else if (nxt > MAX_S)
      return MAX_U;
    else
      return nxt[7:0];
  endfunction

  assign cmd_ready  = en && (state_q == IDLE) && !estop_w;
  assign accept     = cmd_valid && cmd_ready;
  assign diff       = signed'({1'b0, target_q}) - signed'({1'b0, duty_q});
  assign abs_diff   = (diff < 0) ? -diff : diff;
  assign last_step  = (abs_diff <= STEP_S);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    target_d  = target_q;
    duty_d    = duty_q;
    clamped_d = clamped_q;
    if (estop_w) begin
      state_d  = IDLE;
      tick_d   = 16'd0;
      target_d = 8'd0;
      duty_d   = 8'd0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            target_d  = sat_target(cmd_duty);
            clamped_d = (cmd_duty > MAX_U);
            tick_d    = 16'd0;
            if (sat_target(cmd_duty) != duty_q)
              state_d = RAMP;
          end
        end
        RAMP: begin
          // The wrap cycle is the tick: the last step lands on the target and ends the ramp.
          if (tick_q == TICK_MAX) begin
            tick_d = 16'd0;
            if (last_step) begin
              duty_d  = target_q;
              state_d = IDLE;
            end else begin
              duty_d = step_toward(signed'({1'b0, duty_q}), diff);
            end
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= 16'd0;
      target_q  <= 8'd0;
      duty_q    <= 8'd0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      clamped_q <= clamped_d;
    end
  end

  assign duty_cycle = duty_q;
  assign busy       = (state_q == RAMP);
  assign clamped    = clamped_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Directed, table-driven bench for duty_ramp (TICK_DIV=4; STEP=1 and STEP=3 instances).
module tb_duty_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready, busy, clamped;
  logic [7:0] duty_cycle;

  logic       en_b, cmd_valid_b;
  logic [7:0] cmd_duty_b;
  logic       cmd_ready_b, busy_b, clamped_b;
  logic [7:0] duty_cycle_b;

`ifdef DUTY_RAMP_ESTOP_EN
  logic estop, estop_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  duty_ramp #(.TICK_DIV(4), .STEP(1), .MAX_DUTY(100)) dut_a (
    .clk(clk), .rst(rst),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop(estop),
`endif
    .en(en), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty), .cmd_ready(cmd_ready),
    .duty_cycle(duty_cycle), .busy(busy), .clamped(clamped)
  );

  duty_ramp #(.TICK_DIV(4), .STEP(3), .MAX_DUTY(100)) dut_b (
    .clk(clk), .rst(rst),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop(estop_b),
`endif
    .en(en_b), .cmd_valid(cmd_valid_b), .cmd_duty(cmd_duty_b), .cmd_ready(cmd_ready_b),
    .duty_cycle(duty_cycle_b), .busy(busy_b), .clamped(clamped_b)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] duty_in;
    int         exp_duty;
    logic       exp_busy;
    logic       exp_ready;
    logic       exp_clamped;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic accept_cmd(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  int exp_b[4] = '{3, 6, 9, 10};

  initial begin
    rst = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_duty = 8'd0;
    en_b = 1'b0; cmd_valid_b = 1'b0; cmd_duty_b = 8'd0;
`ifdef DUTY_RAMP_ESTOP_EN
    estop = 1'b0; estop_b = 1'b0;
`endif

    // Command 3 from 0: accept, then one unit every 4 cycles; a mid-ramp offer of 50 is ignored.
    vecs[0] = '{1'b1, 1'b1, 8'd3, 0, 1'b1, 1'b0, 1'b0};
    for (int i = 1; i < 13; i++)
      vecs[i] = '{1'b1, (i == 2), 8'd50, i / 4, (i < 12), (i == 12), 1'b0};

    #1;
    chk("rst duty", duty_cycle, 0);
    chk("rst busy", busy, 0);
    chk("rst clamped", clamped, 0);
    chk("rst ready en0", cmd_ready, 0);
    en = 1'b1;
    #1;
    chk("rst ready en1", cmd_ready, 1);
    rst = 1'b1;
    tick();
    chk("idle duty", duty_cycle, 0);
    chk("idle ready", cmd_ready, 1);

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; cmd_valid = vecs[i].vld; cmd_duty = vecs[i].duty_in;
      tick();
      chk($sformatf("vec%0d duty", i), duty_cycle, vecs[i].exp_duty);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d ready", i), cmd_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d clamped", i), clamped, vecs[i].exp_clamped);
    end
    cmd_valid = 1'b0;

    // Clamp: 150 -> 100 in 400 cycles, then 50 ramps back down in 200.
    do_reset();
    accept_cmd(8'd150);
    chk("clamp flag", clamped, 1);
    chk("clamp busy", busy, 1);
    repeat (399) tick();
    chk("clamp duty 399", duty_cycle, 99);
    chk("clamp busy 399", busy, 1);
    tick();
    chk("clamp duty 400", duty_cycle, 100);
    chk("clamp busy 400", busy, 0);
    accept_cmd(8'd50);
    chk("down clamped", clamped, 0);
    chk("down busy", busy, 1);
    repeat (199) tick();
    chk("down duty 199", duty_cycle, 51);
    tick();
    chk("down duty 200", duty_cycle, 50);
    chk("down busy 200", busy, 0);

    // Enable freeze mid-ramp delays the next step by exactly the frozen cycles.
    do_reset();
    accept_cmd(8'd3);
    repeat (6) tick();
    chk("frz pre duty", duty_cycle, 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("frz%0d duty", k), duty_cycle, 1);
      chk($sformatf("frz%0d busy", k), busy, 1);
      chk($sformatf("frz%0d ready", k), cmd_ready, 0);
    end
    en = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd77;
    #1;
    chk("frz ramp ready", cmd_ready, 0);
    tick();
    chk("frz resume1 duty", duty_cycle, 1);
    tick();
    chk("frz resume2 duty", duty_cycle, 2);
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("frz end duty", duty_cycle, 3);
    chk("frz end busy", busy, 0);
    chk("frz end clamped", clamped, 0);

    // Asynchronous reset mid-ramp at duty 40, then a no-op command of 0.
    do_reset();
    accept_cmd(8'd80);
    repeat (160) tick();
    chk("mid duty 40", duty_cycle, 40);
    repeat (2) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst duty", duty_cycle, 0);
    chk("arst busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("arst ready", cmd_ready, 1);
    accept_cmd(8'd0);
    chk("same busy", busy, 0);
    chk("same duty", duty_cycle, 0);
    chk("same ready", cmd_ready, 1);

    // STEP=3 instance: 0 -> 10 reads 3, 6, 9, 10.
    en_b = 1'b1; cmd_valid_b = 1'b1; cmd_duty_b = 8'd10;
    tick();
    cmd_valid_b = 1'b0;
    chk("b busy", busy_b, 1);
    for (int s = 0; s < 4; s++) begin
      repeat (4) tick();
      chk($sformatf("b step%0d duty", s), duty_cycle_b, exp_b[s]);
      chk($sformatf("b step%0d busy", s), busy_b, (s < 3) ? 1 : 0);
    end

`ifdef DUTY_RAMP_ESTOP_EN
    // Emergency stop overrides a disabled block at duty 60.
    do_reset();
    accept_cmd(8'd80);
    repeat (240) tick();
    chk("es pre duty", duty_cycle, 60);
    en = 1'b0; estop = 1'b1;
    #1;
    chk("es ready0", cmd_ready, 0);
    tick();
    chk("es duty", duty_cycle, 0);
    chk("es busy", busy, 0);
    en = 1'b1;
    tick();
    chk("es hold ready", cmd_ready, 0);
    chk("es hold duty", duty_cycle, 0);
    estop = 1'b0;
    #1;
    chk("es release ready", cmd_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
